mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the video/CPU memory arbiter: FSM states, width defaults, owner codes.
// Owner codes identify whose status lines the controller's handshakes are steered to.
package mem_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_V = 2'd1,
    GRANT_C = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_VID  = 2'd1;
  localparam logic [1:0] OWNER_CPU  = 2'd2;

  function automatic logic [1:0] state_owner(arb_state_e s);
    case (s)
      GRANT_V: return OWNER_VID;
      GRANT_C: return OWNER_CPU;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: video has priority; the CPU follows a video op directly.
// Request captured on the grant edge, m_req valid next cycle and held until m_op_begun.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              v_req,
  input  logic              v_rd,
  input  logic              v_burst,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_op_begun,
  output logic              v_op_finished,
  output logic              v_data_ok,
  input  logic              c_req,
  input  logic              c_rd,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_op_begun,
  output logic              c_op_finished,
  output logic              c_data_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              m_req,
  output logic              m_rd,
  output logic              m_burst,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_op_begun,
  input  logic              m_op_finished,
  input  logic              m_data_ok,
  input  logic              ctrlr_good,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              burst_q, burst_d;
  logic              req_q, req_d;
  logic              grant_v, grant_c;
  logic [1:0]        owner;

  // Next-state: ctrlr_good only gates new grants, never an ongoing one.
  always_comb begin
    grant_v = 1'b0;
    grant_c = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrlr_good) begin
          grant_v = v_req;
          grant_c = !v_req && c_req;
        end
      end
      GRANT_V: begin
        if (m_op_finished) begin
          grant_c = c_req && ctrlr_good;
          state_d = IDLE;
        end
      end
      GRANT_C: begin
        if (m_op_finished) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant_v) state_d = GRANT_V;
    if (grant_c) state_d = GRANT_C;
  end

  // Captured request; wdata is only meaningful for CPU writes, so video grants leave it alone.
  always_comb begin
    addr_d  = addr_q;
    rd_d    = rd_q;
    burst_d = burst_q;
    wdata_d = wdata_q;
    req_d   = req_q && !m_op_begun;
    if (m_op_finished && state_q != IDLE) req_d = 1'b0;
    if (grant_v) begin
      addr_d  = v_addr;
      rd_d    = v_rd;
      burst_d = v_burst;
      req_d   = 1'b1;
    end else if (grant_c) begin
      addr_d  = c_addr;
      rd_d    = c_rd;
      burst_d = 1'b0;
      wdata_d = c_wdata;
      req_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      burst_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      burst_q <= burst_d;
      req_q   <= req_d;
    end
  end

  assign owner = state_owner(state_q);

  assign m_req   = req_q;
  assign m_rd    = rd_q;
  assign m_burst = burst_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign rdata   = m_rdata;

  assign v_op_begun    = (owner == OWNER_VID) && m_op_begun;
  assign v_op_finished = (owner == OWNER_VID) && m_op_finished;
  assign v_data_ok     = (owner == OWNER_VID) && m_data_ok;
  assign c_op_begun    = (owner == OWNER_CPU) && m_op_begun;
  assign c_op_finished = (owner == OWNER_CPU) && m_op_finished;
  assign c_data_ok     = (owner == OWNER_CPU) && m_data_ok;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases, then random traffic against a grant-record model.
module tb_mem_arbiter;

  localparam int AW    = 23;
  localparam int DW    = 16;
  localparam int OWN_V = 1;
  localparam int OWN_C = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          v_req, v_rd, v_burst;
  logic [AW-1:0] v_addr;
  logic          v_op_begun, v_op_finished, v_data_ok;
  logic          c_req, c_rd;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_op_begun, c_op_finished, c_data_ok;
  logic [DW-1:0] rdata;
  logic          m_req, m_rd, m_burst;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_op_begun, m_op_finished, m_data_ok, ctrlr_good;
  logic [DW-1:0] m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the grant currently in force, as a record of who owns it and what was captured.
  bit            g_act, g_begun;
  int            g_own;
  logic [AW-1:0] e_addr;
  logic          e_rd, e_burst;
  logic [DW-1:0] e_wdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .v_req(v_req), .v_rd(v_rd), .v_burst(v_burst), .v_addr(v_addr),
    .v_op_begun(v_op_begun), .v_op_finished(v_op_finished), .v_data_ok(v_data_ok),
    .c_req(c_req), .c_rd(c_rd), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_op_begun(c_op_begun), .c_op_finished(c_op_finished), .c_data_ok(c_data_ok),
    .rdata(rdata),
    .m_req(m_req), .m_rd(m_rd), .m_burst(m_burst), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_op_begun(m_op_begun), .m_op_finished(m_op_finished), .m_data_ok(m_data_ok),
    .ctrlr_good(ctrlr_good), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    g_act = 1'b0; g_begun = 1'b0; g_own = 0;
    e_addr = '0; e_rd = 1'b0; e_burst = 1'b0; e_wdata = '0;
  endtask

  task automatic model_start(input int who);
    g_act = 1'b1; g_begun = 1'b0; g_own = who;
    if (who == OWN_V) begin
      e_addr = v_addr; e_rd = v_rd; e_burst = v_burst;
    end else begin
      e_addr = c_addr; e_rd = c_rd; e_burst = 1'b0; e_wdata = c_wdata;
    end
  endtask

  // Applies the arbitration rules to the inputs present at a rising edge.
  task automatic model_edge();
    int prev;
    if (!reset) begin
      model_clear();
    end else if (g_act) begin
      if (m_op_begun) g_begun = 1'b1;
      if (m_op_finished) begin
        prev  = g_own;
        g_act = 1'b0;
        g_own = 0;
        if (prev == OWN_V && c_req && ctrlr_good) model_start(OWN_C);
      end
    end else if (ctrlr_good) begin
      if (v_req) model_start(OWN_V);
      else if (c_req) model_start(OWN_C);
    end
  endtask

  task automatic check_outputs();
    bit ov, oc;
    ov = g_act && g_own == OWN_V;
    oc = g_act && g_own == OWN_C;
    check_eq("m_req",     64'(m_req),         64'(g_act && !g_begun));
    check_eq("m_addr",    64'(m_addr),        64'(e_addr));
    check_eq("m_rd",      64'(m_rd),          64'(e_rd));
    check_eq("m_burst",   64'(m_burst),       64'(e_burst));
    check_eq("m_wdata",   64'(m_wdata),       64'(e_wdata));
    check_eq("v_begun",   64'(v_op_begun),    64'(ov && m_op_begun));
    check_eq("v_finish",  64'(v_op_finished), 64'(ov && m_op_finished));
    check_eq("v_data_ok", 64'(v_data_ok),     64'(ov && m_data_ok));
    check_eq("c_begun",   64'(c_op_begun),    64'(oc && m_op_begun));
    check_eq("c_finish",  64'(c_op_finished), 64'(oc && m_op_finished));
    check_eq("c_data_ok", 64'(c_data_ok),     64'(oc && m_data_ok));
    check_eq("rdata",     64'(rdata),         64'(m_rdata));
  endtask

  // Check on the falling edge, update the model on the rising edge, return 1 time unit later.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_ctrl();
    m_op_begun = 1'b0; m_op_finished = 1'b0; m_data_ok = 1'b0;
  endtask

  initial begin
    v_req = 0; v_rd = 0; v_burst = 0; v_addr = '0;
    c_req = 0; c_rd = 0; c_addr = '0; c_wdata = '0;
    ctrlr_good = 1'b1; m_rdata = 16'h5A5A;
    idle_ctrl();
    model_clear();
    repeat (3) tick();
    reset = 1'b1;

    // Simultaneous requests: video wins, CPU status stays masked.
    v_req = 1; c_req = 1; v_addr = 23'h1A2B3C; v_burst = 1; v_rd = 1;
    c_addr = 23'h0055AA; c_rd = 1;
    tick();
    check_eq("both_addr",  64'(m_addr),  64'(23'h1A2B3C));
    check_eq("both_burst", 64'(m_burst), 64'(1));
    check_eq("both_req",   64'(m_req),   64'(1));
    m_op_begun = 1'b1;
    #1;
    check_eq("both_c_begun", 64'(c_op_begun), 64'(0));
    check_eq("both_v_begun", 64'(v_op_begun), 64'(1));

    // Zero-length video op ends with CPU waiting: CPU granted on the same edge.
    m_op_finished = 1'b1; v_req = 0; c_req = 1;
    c_addr = 23'h000123; c_wdata = 16'hBEEF; c_rd = 0;
    tick();
    check_eq("handoff_addr",  64'(m_addr),  64'(23'h000123));
    check_eq("handoff_wdata", 64'(m_wdata), 64'(16'hBEEF));
    check_eq("handoff_rd",    64'(m_rd),    64'(0));
    check_eq("handoff_burst", 64'(m_burst), 64'(0));
    check_eq("handoff_req",   64'(m_req),   64'(1));

    // Slow acceptance; requester changes must not leak into the grant.
    idle_ctrl();
    c_req = 0; v_req = 1; v_addr = 23'h3FFFFF; c_addr = 23'h111111; c_wdata = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_req",  64'(m_req),  64'(1));
      check_eq("hold_addr", 64'(m_addr), 64'(23'h000123));
    end
    m_op_begun = 1'b1;
    tick();
    check_eq("accept_req", 64'(m_req), 64'(0));
    m_op_begun = 1'b0; m_op_finished = 1'b1; v_req = 0;
    tick();
    idle_ctrl();

    // Controller not ready: no grant at all, then video once it is.
    ctrlr_good = 1'b0; v_req = 1; c_req = 1; v_addr = 23'h7F0001; v_burst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("notgood_req", 64'(m_req), 64'(0));
    end
    ctrlr_good = 1'b1;
    tick();
    check_eq("good_req",  64'(m_req),  64'(1));
    check_eq("good_addr", 64'(m_addr), 64'(23'h7F0001));
    v_req = 0; c_req = 0; m_op_begun = 1'b1; m_op_finished = 1'b1;
    tick();
    check_eq("zero_len_req", 64'(m_req), 64'(0));
    idle_ctrl();
    tick();

    // Asynchronous reset in the middle of a CPU grant.
    c_req = 1; c_addr = 23'h000456; c_wdata = 16'h1234; c_rd = 1;
    tick();
    c_req = 0; m_op_begun = 1'b1; m_data_ok = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_eq("arst_req",     64'(m_req),      64'(0));
    check_eq("arst_addr",    64'(m_addr),     64'(0));
    check_eq("arst_wdata",   64'(m_wdata),    64'(0));
    check_eq("arst_rd",      64'(m_rd),       64'(0));
    check_eq("arst_c_begun", 64'(c_op_begun), 64'(0));
    check_eq("arst_c_ok",    64'(c_data_ok),  64'(0));
    tick();
    idle_ctrl();
    reset = 1'b1;
    c_req = 1; v_req = 0; c_addr = 23'h000789;
    tick();
    check_eq("post_rst_addr", 64'(m_addr), 64'(23'h000789));
    check_eq("post_rst_req",  64'(m_req),  64'(1));
    m_op_begun = 1'b1;
    #1;
    check_eq("post_rst_c_begun", 64'(c_op_begun), 64'(1));
    c_req = 0; m_op_finished = 1'b1;
    tick();
    idle_ctrl();

    // Random traffic; the controller side reacts to the model's view of the grant.
    for (int n = 0; n < 3000; n++) begin
      v_req      = ($urandom_range(0, 2) != 0);
      v_rd       = 1'($urandom);
      v_burst    = 1'($urandom);
      v_addr     = AW'($urandom);
      c_req      = 1'($urandom);
      c_rd       = 1'($urandom);
      c_addr     = AW'($urandom);
      c_wdata    = DW'($urandom);
      ctrlr_good = ($urandom_range(0, 7) != 0);
      m_rdata    = DW'($urandom);
      idle_ctrl();
      if (g_act) begin
        if (!g_begun) begin
          m_op_begun    = ($urandom_range(0, 2) == 0);
          m_op_finished = m_op_begun && ($urandom_range(0, 3) == 0);
        end else begin
          m_data_ok     = 1'($urandom);
          m_op_finished = ($urandom_range(0, 2) == 0);
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
